dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit storage words, power of two, minimum 4.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from request acceptance to rsp_valid, range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1: request handshake.
REQ-006 SHALL have ports req_we input 1, req_addr input 32 and req_wdata input 32: write enable, byte address and write data.
REQ-007 SHALL have port req_wstrb  input  4  byte-lane write enables; lane i covers bits 8i+7:8i.
REQ-008 SHALL have ports rsp_valid output 1 and rsp_ready input 1: response handshake.
REQ-009 SHALL have ports rsp_rdata output 32 and rsp_err output 1: read data and error flag.

Function
REQ-010 SHALL implement states IDLE, WAIT and RESP.
REQ-011 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-012 SHALL register req_we, word index, req_wdata and req_wstrb on acceptance; later request-input changes SHALL have no effect.
REQ-013 SHALL go IDLE->RESP on acceptance when LATENCY=1, else IDLE->WAIT with a down-counter loaded with LATENCY-1.
REQ-014 SHALL go WAIT->RESP when the counter reaches 1 (decrementing each cycle), giving rsp_valid exactly LATENCY cycles after acceptance.
REQ-015 SHALL, on the edge entering RESP, commit a write (only lanes with wstrb=1) or capture a read into rsp_rdata.
REQ-016 SHALL use word index req_addr[log2(DEPTH_WORDS)+1:2].
REQ-017 SHALL drive rsp_valid=1 only in RESP, holding rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready.
REQ-018 SHALL go RESP->IDLE on the response handshake; the next request can be accepted no earlier than the following edge.
REQ-019 SHALL drive rsp_rdata=0 for write responses.
REQ-020 SHALL perform exactly one storage write per accepted write request; req_wstrb=0 is a legal no-op write with a normal response.
REQ-021 SHALL leave storage contents undefined after power-up; no read-before-write value is guaranteed.

Reset
REQ-022 SHALL, while rst=0, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, asynchronously.
REQ-023 SHALL drive req_ready=1 on the first cycle after rst deasserts.
REQ-024 SHALL, on reset asserted in WAIT, drop the pending request with no storage write.
REQ-025 SHALL, on reset asserted in RESP, drop the pending response; a write committed on RESP entry remains in storage.
REQ-026 SHALL NOT reset storage contents.

Configuration
REQ-027 SHALL support macro DMEM_RESP_ERR_EN.
REQ-028 SHALL, with DMEM_RESP_ERR_EN defined, set rsp_err=1 when req_addr[1:0]!=0 or req_addr>=4*DEPTH_WORDS.
REQ-029 SHALL, with DMEM_RESP_ERR_EN defined, suppress the storage write and return rsp_rdata=0 for an errored request, with timing unchanged.
REQ-030 SHALL, with DMEM_RESP_ERR_EN undefined, tie rsp_err to 0, ignore req_addr[1:0] and wrap addresses modulo 4*DEPTH_WORDS.

Verification
REQ-031 SHALL cover, with LATENCY=1, write 0xDEADBEEF to 0x10 (wstrb=0xF) then read 0x10 -> rsp_valid 1 cycle after each acceptance, read rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-032 SHALL cover a byte-strobe merge: write 0x11223344 to 0x20, then 0xAABBCCDD with wstrb=0x5, then read 0x20 -> rsp_rdata=0x11BB33DD.
REQ-033 SHALL cover back-pressure: LATENCY=3, read with rsp_ready held 0 for 5 cycles -> rsp_valid rises 3 cycles after acceptance, data stable, req_ready=0 throughout, req_ready=1 the cycle after the handshake.
REQ-034 SHALL cover errors: with DMEM_RESP_ERR_EN, write to 0x13 and read from 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, storage unchanged; without the macro, the read of 4*DEPTH_WORDS returns word 0.
REQ-035 SHALL cover reset mid-operation: LATENCY=4, write 0xCAFEF00D to 0x40, assert rst in WAIT -> outputs 0 immediately, req_ready=1 the cycle after release, a read of 0x40 does not return 0xCAFEF00D unless previously written.

Source files
------------

// File: rtl/dmem_resp.sv
// Single-port word memory with a request/response handshake; the response appears LATENCY cycles after acceptance and is held until rsp_ready.
// One request in flight (req_ready only when idle). Define DMEM_RESP_ERR_EN to flag misaligned or out-of-range accesses.
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic            accept;
    logic            enter_resp;
    logic            req_err;

    logic            r_we;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_err;

    logic            c_we;
    logic [AW-1:0]   c_idx;
    logic [31:0]     c_wdata;
    logic [3:0]      c_wstrb;
    logic            c_err;

    logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_RESP_ERR_EN
    assign req_err = (req_addr[1:0] != 2'b00) ||
                     ({1'b0, req_addr} >= (33'(DEPTH_WORDS) << 2));
`else
    assign req_err = 1'b0;
`endif

    // Address bits outside the word index only matter for error detection.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign req_ready = rst && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the commit happens on the accepting edge, so take the live request.
    always_comb begin
        c_we    = r_we;
        c_idx   = r_idx;
        c_wdata = r_wdata;
        c_wstrb = r_wstrb;
        c_err   = r_err;
        if (state == IDLE) begin
            c_we    = req_we;
            c_idx   = req_addr[AW+1:2];
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
            c_err   = req_err;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    cnt_nxt    = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_err     <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                r_we    <= req_we;
                r_idx   <= req_addr[AW+1:2];
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_err   <= req_err;
            end
            if (enter_resp) begin
                rsp_rdata <= (c_we || c_err) ? 32'd0 : mem[c_idx];
                rsp_err   <= c_err;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enter_resp && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp at LATENCY 1, 3 and 4 with a transaction-level reference model.
module tb_dmem_resp;

    localparam int DEPTH = 32;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NDUT];
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_we    [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [3:0]  req_wstrb [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];

    dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_wstrb(req_wstrb[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    int vectors = 0;
    int miscompares = 0;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
        vectors++;
        if (act === bad) begin
            miscompares++;
            $display("FAIL %s: got %h, must differ from %h", name, act, bad);
        end
    endtask

    // Reference model: one outstanding transaction per instance, tracked by
    // cycles since acceptance; storage is a byte-validity-tracked array.
    int          m_phase [NDUT];
    int          m_cyc   [NDUT];
    logic        m_we    [NDUT];
    int          m_idx   [NDUT];
    logic [31:0] m_wdata [NDUT];
    logic [3:0]  m_wstrb [NDUT];
    logic        m_err   [NDUT];
    logic [31:0] m_rdata [NDUT];
    bit          m_rkn   [NDUT];
    logic [31:0] mmem    [NDUT][DEPTH];
    bit   [3:0]  mkn     [NDUT][DEPTH];

    function automatic void model_commit(input int d);
        m_rdata[d] = 32'd0;
        m_rkn[d]   = 1'b1;
        if (m_we[d]) begin
            if (!m_err[d]) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_wstrb[d][i]) begin
                        mmem[d][m_idx[d]][8*i +: 8] = m_wdata[d][8*i +: 8];
                        mkn[d][m_idx[d]][i] = 1'b1;
                    end
                end
            end
        end else if (!m_err[d]) begin
            m_rdata[d] = mmem[d][m_idx[d]];
            m_rkn[d]   = (mkn[d][m_idx[d]] == 4'hF);
        end
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (!rst[d]) begin
                m_phase[d] = 0;
            end else if (m_phase[d] == 0) begin
                if (req_valid[d]) begin
                    m_phase[d] = 1;
                    m_cyc[d]   = 0;
                    m_we[d]    = req_we[d];
                    m_idx[d]   = int'((req_addr[d] >> 2) & 32'(DEPTH - 1));
                    m_wdata[d] = req_wdata[d];
                    m_wstrb[d] = req_wstrb[d];
`ifdef DMEM_RESP_ERR_EN
                    m_err[d] = (req_addr[d] % 4 != 0) || (req_addr[d] >= 32'(4 * DEPTH));
`else
                    m_err[d] = 1'b0;
`endif
                    if (lat_of(d) == 1) model_commit(d);
                end
            end else if (m_cyc[d] >= lat_of(d) - 1) begin
                if (rsp_ready[d]) m_phase[d] = 0;
            end else begin
                m_cyc[d]++;
                if (m_cyc[d] == lat_of(d) - 1) model_commit(d);
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            bit ev;
            if (!rst[d]) begin
                check($sformatf("d%0d rst req_ready", d), 32'(req_ready[d]), 32'd0);
                check($sformatf("d%0d rst rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
                check($sformatf("d%0d rst rsp_rdata", d), rsp_rdata[d], 32'd0);
                check($sformatf("d%0d rst rsp_err", d), 32'(rsp_err[d]), 32'd0);
            end else begin
                ev = (m_phase[d] == 1) && (m_cyc[d] >= lat_of(d) - 1);
                check($sformatf("d%0d req_ready", d), 32'(req_ready[d]), 32'(m_phase[d] == 0));
                check($sformatf("d%0d rsp_valid", d), 32'(rsp_valid[d]), 32'(ev));
                if (ev) begin
                    check($sformatf("d%0d rsp_err", d), 32'(rsp_err[d]), 32'(m_err[d]));
                    if (m_rkn[d]) check($sformatf("d%0d rsp_rdata", d), rsp_rdata[d], m_rdata[d]);
                end
            end
        end
    end

    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        int   guard;
        logic rdy;
        bit   ok;
        rdata = 32'd0;
        err   = 1'b0;
        lat   = 0;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = wstrb;
        guard = 0;
        ok    = 1'b0;
        while (!ok && guard < 50) begin
            @(negedge clk);
            rdy = req_ready[d];
            @(posedge clk);
            if (rdy) ok = 1'b1;
            guard++;
        end
        #1;
        // Scramble the request fields after acceptance; they must not matter.
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_wstrb[d] = 4'($urandom);
        if (!ok) begin
            check($sformatf("d%0d accept timeout", d), 32'(ok), 32'd1);
            return;
        end
        ok = 1'b0;
        while (!ok && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[d]) ok = 1'b1;
        end
        if (!ok) begin
            check($sformatf("d%0d rsp timeout", d), 32'(ok), 32'd1);
            return;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold rsp_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold rsp_rdata stable", rsp_rdata[d], rdata);
            check("hold rsp_err stable", 32'(rsp_err[d]), 32'(err));
            check("hold req_ready low", 32'(req_ready[d]), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_wstrb[d] = 4'd0; rsp_ready[d] = 1'b0;
            m_phase[d] = 0; m_cyc[d] = 0; m_rkn[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b1;
        @(negedge clk);
        check("req_ready after reset release", 32'(req_ready[0]), 32'd1);

        // Full-word write then read back, LATENCY=1.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lt);
        check("wr latency L1", 32'(lt), 32'd1);
        check("wr rdata zero", rd, 32'd0);
        check("wr err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lt);
        check("rd latency L1", 32'(lt), 32'd1);
        check("rd 0x10", rd, 32'hDEADBEEF);
        check("rd err", 32'(er), 32'd0);

        // Byte-strobe merge and a zero-strobe no-op write.
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lt);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, er, lt);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lt);
        check("strobe merge", rd, 32'h11BB33DD);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lt);
        check("wstrb0 err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lt);
        check("wstrb0 no-op", rd, 32'h11BB33DD);

        // Out-of-range and misaligned accesses.
        txn(0, 1'b1, 32'h0, 32'h5A5A0001, 4'hF, 0, rd, er, lt);
        txn(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, rd, er, lt);
`ifdef DMEM_RESP_ERR_EN
        check("oor read err", 32'(er), 32'd1);
        check("oor read rdata", rd, 32'd0);
`else
        check("wrap read err", 32'(er), 32'd0);
        check("wrap read word0", rd, 32'h5A5A0001);
`endif
        txn(0, 1'b1, 32'h13, 32'h0BADF00D, 4'hF, 0, rd, er, lt);
        check("misaligned wr latency", 32'(lt), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lt);
`ifdef DMEM_RESP_ERR_EN
        check("errored write suppressed", rd, 32'hDEADBEEF);
`else
        check("misaligned write lands", rd, 32'h0BADF00D);
`endif

        // Back-pressure with LATENCY=3.
        txn(1, 1'b1, 32'h44, 32'h600DCAFE, 4'hF, 0, rd, er, lt);
        check("wr latency L3", 32'(lt), 32'd3);
        txn(1, 1'b0, 32'h44, 32'h0, 4'h0, 5, rd, er, lt);
        check("rd latency L3", 32'(lt), 32'd3);
        check("rd L3 data", rd, 32'h600DCAFE);
        @(negedge clk);
        check("req_ready after handshake", 32'(req_ready[1]), 32'd1);

        // Reset while a LATENCY=4 write waits.
        @(posedge clk);
        #1;
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h40;
        req_wdata[2] = 32'hCAFEF00D; req_wstrb[2] = 4'hF;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        #1 rst[2] = 1'b0;
        #1;
        check("mid reset rsp_valid", 32'(rsp_valid[2]), 32'd0);
        check("mid reset req_ready", 32'(req_ready[2]), 32'd0);
        check("mid reset rsp_rdata", rsp_rdata[2], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst[2] = 1'b1;
        @(negedge clk);
        check("req_ready after mid reset", 32'(req_ready[2]), 32'd1);
        txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lt);
        check("rd latency L4", 32'(lt), 32'd4);
        check_ne("dropped write absent", rd, 32'hCAFEF00D);
        txn(2, 1'b1, 32'h48, 32'h12345678, 4'hC, 0, rd, er, lt);
        txn(2, 1'b1, 32'h48, 32'h9ABCDEF0, 4'h3, 0, rd, er, lt);
        txn(2, 1'b0, 32'h48, 32'h0, 4'h0, 2, rd, er, lt);
        check("L4 merged read", rd, 32'h1234DEF0);

        // Mixed aligned traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 24; i++) begin
            int d;
            d = i % 2;
            txn(d, 1'($urandom), 32'($urandom_range(0, DEPTH - 1) * 4), $urandom,
                4'($urandom), int'($urandom_range(0, 2)), rd, er, lt);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
